// File: rtl/e_scale_requant.sv
// Per-channel requantiser: signed pixel * unsigned scale tail, rounded right shift, saturate to OUT_WIDTH (optional ReLU).
// Latency: 3 clk from accept to out_valid, 1 row/clk sustained.
// Backpressure: one global advance enable stalls every stage; in_ready = out_ready || !out_valid.
//
// Ports:
//   clk, quantify_reset         clock, synchronous active-high reset
//   mode, relu_en               table indexing mode (0: shared entry, 1: entry per channel), ReLU clamp
//   in_valid/in_ready/in_row    input row handshake; pixel (c,l) at index c*LANES+l
//   in_chan_base                first scale-table entry used by the row
//   tbl_we/tbl_addr/tbl_tail/tbl_rank  scale-table write port (independent of stalls)
//   out_valid/out_ready/out_row output row handshake, same pixel ordering as in_row
//   sat_clear/sat_count         saturated-pixel counter (sticky at all-ones) and its clear
module e_scale_requant #(
    parameter int LANES         = 32,
    parameter int CHANNELS      = 2,
    parameter int PIXEL_WIDTH   = 24,
    parameter int TAIL_WIDTH    = 16,
    parameter int RANK_WIDTH    = 6,
    parameter int OUT_WIDTH     = 8,
    parameter int TABLE_DEPTH   = 64,
    parameter int SAT_CNT_WIDTH = 16,
    parameter int ADDR_W        = $clog2(TABLE_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  quantify_reset,
    input  logic                                  mode,
    input  logic                                  relu_en,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [LANES*CHANNELS*PIXEL_WIDTH-1:0] in_row,
    input  logic [ADDR_W-1:0]                     in_chan_base,
    input  logic                                  tbl_we,
    input  logic [ADDR_W-1:0]                     tbl_addr,
    input  logic [TAIL_WIDTH-1:0]                 tbl_tail,
    input  logic [RANK_WIDTH-1:0]                 tbl_rank,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES*CHANNELS*OUT_WIDTH-1:0]   out_row,
    input  logic                                  sat_clear,
    output logic [SAT_CNT_WIDTH-1:0]              sat_count
);

    localparam int NPIX      = LANES * CHANNELS;
    localparam int PROD_W    = PIXEL_WIDTH + TAIL_WIDTH + 1;
    // One extra bit so that adding the rounding constant can never overflow.
    localparam int EXT_W     = PROD_W + 1;
    localparam int MAX_SHIFT = PIXEL_WIDTH + TAIL_WIDTH;
    localparam int ENTRY_W   = TAIL_WIDTH + RANK_WIDTH;
    localparam int CNT_W     = $clog2(NPIX + 1);

    localparam logic signed [EXT_W-1:0] Q_MAX = (EXT_W'(1) <<< (OUT_WIDTH - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] Q_MIN = -Q_MAX - EXT_W'(1);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] q;
        logic                 sat;
    } rq_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                    input int                c);
        int s;
        s = int'(base) + c;
        s = s % TABLE_DEPTH;
        return ADDR_W'(s);
    endfunction

    // Tail is unsigned: zero-extend it so the signed multiply treats it as positive.
    function automatic logic signed [PROD_W-1:0] mul(input logic signed [PIXEL_WIDTH-1:0] p,
                                                     input logic [TAIL_WIDTH-1:0]         t);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = PROD_W'(p);
        b = $signed(PROD_W'(t));
        return a * b;
    endfunction

    function automatic rq_t requant(input logic signed [PROD_W-1:0] p,
                                    input logic [RANK_WIDTH-1:0]   rank,
                                    input logic                    relu);
        rq_t                     res;
        int                      r;
        logic signed [EXT_W-1:0] rnd;
        logic signed [EXT_W-1:0] q;
        // Shifts beyond the product's magnitude bits are all equivalent; clamp them.
        r   = (int'(rank) > MAX_SHIFT) ? MAX_SHIFT : int'(rank);
        rnd = (r == 0) ? '0 : (EXT_W'(1) <<< (r - 1));
        q   = (EXT_W'(p) + rnd) >>> r;
        res.sat = 1'b0;
        if (relu && q[EXT_W-1]) begin
            // ReLU zeroing is a clamp by design, not an overflow.
            res.q = '0;
        end else if (q > Q_MAX) begin
            res.q   = Q_MAX[OUT_WIDTH-1:0];
            res.sat = 1'b1;
        end else if (q < Q_MIN) begin
            res.q   = Q_MIN[OUT_WIDTH-1:0];
            res.sat = 1'b1;
        end else begin
            res.q = q[OUT_WIDTH-1:0];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Scale table: {tail, rank} per entry, not reset
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] tbl [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (tbl_we && !quantify_reset) begin
            tbl[tbl_addr] <= {tbl_tail, tbl_rank};
        end
    end

    // Combinational read sampled at the same edge as a write sees the old entry.
    logic [TAIL_WIDTH-1:0] look_tail [CHANNELS];
    logic [RANK_WIDTH-1:0] look_rank [CHANNELS];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            {look_tail[c], look_rank[c]} = tbl[mode ? wrap_addr(in_chan_base, c) : in_chan_base];
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic adv;
    logic s1_vld;
    logic s2_vld;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // S1: captured row and looked-up scale entries
    // ------------------------------------------------------------------
    logic [NPIX*PIXEL_WIDTH-1:0] s1_row;
    logic                        s1_relu;
    logic [TAIL_WIDTH-1:0]       s1_tail [CHANNELS];
    logic [RANK_WIDTH-1:0]       s1_rank [CHANNELS];

    // ------------------------------------------------------------------
    // S2: products
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_d  [NPIX];
    logic signed [PROD_W-1:0] s2_prod [NPIX];
    logic [RANK_WIDTH-1:0]    s2_rank [CHANNELS];
    logic                     s2_relu;

    always_comb begin
        for (int i = 0; i < NPIX; i++) begin
            prod_d[i] = mul(s1_row[i*PIXEL_WIDTH +: PIXEL_WIDTH], s1_tail[i / LANES]);
        end
    end

    // ------------------------------------------------------------------
    // S3: shift / round / saturate into the output register
    // ------------------------------------------------------------------
    rq_t                        rq_d [NPIX];
    logic [NPIX*OUT_WIDTH-1:0]  out_row_d;
    logic [CNT_W-1:0]           row_sat_d;
    logic [CNT_W-1:0]           s3_sat;

    always_comb begin
        out_row_d = '0;
        row_sat_d = '0;
        for (int i = 0; i < NPIX; i++) begin
            rq_d[i] = requant(s2_prod[i], s2_rank[i / LANES], s2_relu);
            out_row_d[i*OUT_WIDTH +: OUT_WIDTH] = rq_d[i].q;
            row_sat_d = row_sat_d + CNT_W'(rq_d[i].sat);
        end
    end

    // Stage data only loads under a valid so idle stages do not toggle.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_row  <= in_row;
            s1_relu <= relu_en;
            for (int c = 0; c < CHANNELS; c++) begin
                s1_tail[c] <= look_tail[c];
                s1_rank[c] <= look_rank[c];
            end
        end
        if (adv && s1_vld) begin
            for (int i = 0; i < NPIX; i++) begin
                s2_prod[i] <= prod_d[i];
            end
            for (int c = 0; c < CHANNELS; c++) begin
                s2_rank[c] <= s1_rank[c];
            end
            s2_relu <= s1_relu;
        end
        if (adv && s2_vld) begin
            s3_sat <= row_sat_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturation counter: counts a row once, on its output handshake.
    // A clear coinciding with a handshake restarts from the new row's count.
    // ------------------------------------------------------------------
    logic                     out_hs;
    logic [SAT_CNT_WIDTH-1:0] sat_base;
    logic [SAT_CNT_WIDTH:0]   sat_sum;
    logic [SAT_CNT_WIDTH-1:0] sat_next;

    assign out_hs = out_valid && out_ready;

    always_comb begin
        sat_base = sat_clear ? '0 : sat_count;
        sat_sum  = {1'b0, sat_base} + (SAT_CNT_WIDTH + 1)'(s3_sat);
        sat_next = sat_sum[SAT_CNT_WIDTH] ? '1 : sat_sum[SAT_CNT_WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Control state with reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (quantify_reset) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            sat_count <= '0;
        end else begin
            if (adv) begin
                s1_vld    <= in_valid;
                s2_vld    <= s1_vld;
                out_valid <= s2_vld;
                if (s2_vld) begin
                    out_row <= out_row_d;
                end
            end
            if (out_hs) begin
                sat_count <= sat_next;
            end else if (sat_clear) begin
                sat_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_e_scale_requant.sv
// Directed-vector bench for e_scale_requant.
// Each scenario task drives its stimulus and checks results against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_e_scale_requant;

    localparam int LANES = 32;
    localparam int N     = 64;
    localparam int PW    = 24;
    localparam int OW    = 8;
    localparam int AW    = 6;
    localparam int TW    = 16;
    localparam int RW    = 6;
    localparam int SW    = 16;

    logic            clk = 1'b0;
    logic            quantify_reset;
    logic            mode;
    logic            relu_en;
    logic            in_valid;
    logic            in_ready;
    logic [N*PW-1:0] in_row;
    logic [AW-1:0]   in_chan_base;
    logic            tbl_we;
    logic [AW-1:0]   tbl_addr;
    logic [TW-1:0]   tbl_tail;
    logic [RW-1:0]   tbl_rank;
    logic            out_valid;
    logic            out_ready;
    logic [N*OW-1:0] out_row;
    logic            sat_clear;
    logic [SW-1:0]   sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    e_scale_requant dut (
        .clk            (clk),
        .quantify_reset (quantify_reset),
        .mode           (mode),
        .relu_en        (relu_en),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_row         (in_row),
        .in_chan_base   (in_chan_base),
        .tbl_we         (tbl_we),
        .tbl_addr       (tbl_addr),
        .tbl_tail       (tbl_tail),
        .tbl_rank       (tbl_rank),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_row        (out_row),
        .sat_clear      (sat_clear),
        .sat_count      (sat_count)
    );

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input int t, input int r);
        tbl_we   = 1'b1;
        tbl_addr = AW'(a);
        tbl_tail = TW'(t);
        tbl_rank = RW'(r);
        tick();
        tbl_we   = 1'b0;
    endtask

    function automatic logic [N*PW-1:0] fill_row(input int v);
        logic [N*PW-1:0] r;
        for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(v);
        return r;
    endfunction

    function automatic logic [N*OW-1:0] fill_out(input int v);
        logic [N*OW-1:0] r;
        for (int i = 0; i < N; i++) r[i*OW +: OW] = OW'(v);
        return r;
    endfunction

    function automatic logic [N*PW-1:0] row_k(input int k);
        logic [N*PW-1:0] r;
        for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(((k * 13 + i) % 100) - 50);
        return r;
    endfunction

    function automatic logic [N*OW-1:0] exp_k(input int k);
        logic [N*OW-1:0] r;
        for (int i = 0; i < N; i++) r[i*OW +: OW] = OW'(((k * 13 + i) % 100) - 50);
        return r;
    endfunction

    // Sends one row with out_ready=1 and waits (bounded) for its output.
    // lat = rising edges from accept (inclusive) until out_valid; -1 on timeout.
    // Returns at the falling edge where the row is visible; its handshake is the next edge.
    task automatic run_row(input logic [N*PW-1:0] row, input int base, input logic m,
                           input logic rl, output logic [N*OW-1:0] res, output int lat);
        in_row       = row;
        in_chan_base = AW'(base);
        mode         = m;
        relu_en      = rl;
        in_valid     = 1'b1;
        lat          = -1;
        res          = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                res = out_row;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        quantify_reset = 1'b1;
        repeat (3) tick();
        quantify_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count: got %0d expected 0", sat_count); end
        checks++;
        if (out_row !== '0) begin errors++; $display("FAIL reset_out_row: got %h expected 0", out_row); end
        tick();
    endtask

    task automatic test_basic();
        logic [N*PW-1:0] r;
        logic [N*OW-1:0] res;
        logic [N*OW-1:0] e;
        int lat;
        load(0, 'h6000, 15);
        load(1, 1, 1);
        r = '0;
        r[0 +: PW] = PW'(100);
        e = '0;
        e[0 +: OW] = OW'(75);
        run_row(r, 0, 1'b1, 1'b0, res, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        checks++;
        if (res !== e) begin errors++; $display("FAIL basic_value: got %h expected %h", res, e); end
        tick();
        checks++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL basic_sat_count: got %0d expected 0", sat_count); end
    endtask

    task automatic test_rounding();
        logic [N*PW-1:0] r;
        logic [N*OW-1:0] res;
        logic [N*OW-1:0] e;
        int lat;
        r = '0;
        r[32*PW +: PW] = PW'(3);
        r[33*PW +: PW] = PW'(-3);
        r[34*PW +: PW] = PW'(1);
        r[35*PW +: PW] = PW'(-1);
        e = '0;
        e[32*OW +: OW] = OW'(2);
        e[33*OW +: OW] = OW'(-1);
        e[34*OW +: OW] = OW'(1);
        e[35*OW +: OW] = OW'(0);
        run_row(r, 0, 1'b1, 1'b0, res, lat);
        tick();
        checks++;
        if (lat < 0 || res !== e) begin errors++; $display("FAIL round_half_up: got %h expected %h (lat %0d)", res, e, lat); end
        e[33*OW +: OW] = OW'(0);
        run_row(r, 0, 1'b1, 1'b1, res, lat);
        tick();
        checks++;
        if (lat < 0 || res !== e) begin errors++; $display("FAIL round_relu: got %h expected %h (lat %0d)", res, e, lat); end
    endtask

    task automatic test_saturation();
        logic [N*PW-1:0] r;
        logic [N*OW-1:0] res;
        logic [N*OW-1:0] e;
        int lat;
        load(0, 'h4000, 14);
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        run_row(fill_row(1000), 0, 1'b0, 1'b0, res, lat);
        tick();
        checks++;
        if (lat < 0 || res !== fill_out(127)) begin errors++; $display("FAIL sat_pos: got %h expected all 7f", res); end
        checks++;
        if (sat_count !== 16'd64) begin errors++; $display("FAIL sat_count_pos: got %0d expected 64", sat_count); end
        run_row(fill_row(-1000), 0, 1'b0, 1'b0, res, lat);
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        checks++;
        if (lat < 0 || res !== fill_out(-128)) begin errors++; $display("FAIL sat_neg: got %h expected all 80", res); end
        checks++;
        if (sat_count !== 16'd64) begin errors++; $display("FAIL sat_clear_on_hs: got %0d expected 64", sat_count); end
        run_row(fill_row(-1000), 0, 1'b0, 1'b1, res, lat);
        tick();
        checks++;
        if (lat < 0 || res !== '0) begin errors++; $display("FAIL sat_relu: got %h expected 0", res); end
        checks++;
        if (sat_count !== 16'd64) begin errors++; $display("FAIL sat_relu_count: got %0d expected 64", sat_count); end
        // Exactly at the limits: no saturation.
        r = '0;
        e = '0;
        for (int i = 0; i < N; i++) begin
            r[i*PW +: PW] = (i < LANES) ? PW'(127) : PW'(-128);
            e[i*OW +: OW] = (i < LANES) ? OW'(127) : OW'(-128);
        end
        run_row(r, 0, 1'b0, 1'b0, res, lat);
        tick();
        checks++;
        if (lat < 0 || res !== e) begin errors++; $display("FAIL sat_edge_value: got %h expected %h", res, e); end
        checks++;
        if (sat_count !== 16'd64) begin errors++; $display("FAIL sat_edge_count: got %0d expected 64", sat_count); end
    endtask

    task automatic test_back_to_back();
        int              sent = 0;
        int              recv = 0;
        bit              prev_stall = 1'b0;
        logic [N*OW-1:0] held = '0;
        load(2, 1, 0);
        in_chan_base = AW'(2);
        mode         = 1'b0;
        relu_en      = 1'b0;
        for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 7);
            in_valid  = (sent < 5);
            in_row    = row_k(sent);
            @(negedge clk);
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", cyc, in_ready); end
                if (prev_stall) begin
                    checks++;
                    if (out_row !== held) begin errors++; $display("FAIL stall_hold: cycle %0d got %h expected %h", cyc, out_row, held); end
                end
                held       = out_row;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_row !== exp_k(recv)) begin errors++; $display("FAIL stream_row%0d: got %h expected %h", recv, out_row, exp_k(recv)); end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv != 5 || sent != 5) begin errors++; $display("FAIL stream_count: got sent %0d recv %0d expected 5 5", sent, recv); end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_extra_row: got out_valid %b expected 0", out_valid); end
            tick();
        end
    endtask

    task automatic test_table_write();
        int got = 0;
        in_chan_base = AW'(2);
        mode         = 1'b0;
        relu_en      = 1'b0;
        in_row       = fill_row(10);
        in_valid     = 1'b1;
        tbl_we       = 1'b1;
        tbl_addr     = AW'(2);
        tbl_tail     = TW'(2);
        tbl_rank     = RW'(0);
        tick();
        tbl_we = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && got < 2; k++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (out_row !== fill_out(got == 0 ? 10 : 20)) begin
                    errors++;
                    $display("FAIL tbl_write_row%0d: got %h expected all %0d", got, out_row, got == 0 ? 10 : 20);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 2) begin errors++; $display("FAIL tbl_write_count: got %0d expected 2", got); end
    endtask

    task automatic test_wrap();
        logic [N*OW-1:0] res;
        logic [N*OW-1:0] e;
        int lat;
        load(63, 3, 0);
        for (int i = 0; i < N; i++) e[i*OW +: OW] = (i < LANES) ? OW'(30) : OW'(10);
        run_row(fill_row(10), 63, 1'b1, 1'b0, res, lat);
        tick();
        checks++;
        if (lat < 0 || res !== e) begin errors++; $display("FAIL mode1_wrap: got %h expected %h", res, e); end
    endtask

    task automatic test_reset_in_flight();
        logic [N*OW-1:0] res;
        int lat;
        int seen = 0;
        load(3, 1, 0);
        in_chan_base = AW'(3);
        mode         = 1'b0;
        relu_en      = 1'b0;
        in_row       = fill_row(5);
        in_valid     = 1'b1;
        tick();
        tick();
        in_valid       = 1'b0;
        quantify_reset = 1'b1;
        tbl_we         = 1'b1;
        tbl_addr       = AW'(3);
        tbl_tail       = TW'(5);
        tbl_rank       = RW'(0);
        tick();
        quantify_reset = 1'b0;
        tbl_we         = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rif_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL rif_sat_count: got %0d expected 0", sat_count); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rif_in_ready: got %b expected 1", in_ready); end
        tick();
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rif_stale_row: got %0d rows expected 0", seen); end
        run_row(fill_row(10), 3, 1'b0, 1'b0, res, lat);
        tick();
        checks++;
        if (lat != 3 || res !== fill_out(10)) begin errors++; $display("FAIL rif_tbl_we_ignored: got %h lat %0d expected all 0a lat 3", res, lat); end
        run_row(fill_row(7), 0, 1'b0, 1'b0, res, lat);
        tick();
        checks++;
        if (lat < 0 || res !== fill_out(7)) begin errors++; $display("FAIL rif_tbl_retained: got %h expected all 07", res); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        quantify_reset = 1'b1;
        mode           = 1'b0;
        relu_en        = 1'b0;
        in_valid       = 1'b0;
        in_row         = '0;
        in_chan_base   = '0;
        tbl_we         = 1'b0;
        tbl_addr       = '0;
        tbl_tail       = '0;
        tbl_rank       = '0;
        out_ready      = 1'b1;
        sat_clear      = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_table_write();
        test_wrap();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_scale_requant.md
Name: e_scale_requant

Overview:
- Parametrised, pipelined requantiser that follows the bias adder in the conv output path.
- Multiplies each signed accumulator pixel by a per-channel unsigned scale tail, then applies a per-channel rank shift with round-half-up.
- Saturates the result to a signed OUT_WIDTH value, with optional ReLU clamp.
- Owns its scale table internally, and adds a valid/ready handshake with full back-pressure.

Parameters:
- LANES, 32, pixels per channel per row
- CHANNELS, 2, output channels carried per row
- PIXEL_WIDTH, 24, signed accumulator pixel width
- TAIL_WIDTH, 16, unsigned scale-tail width
- RANK_WIDTH, 6, unsigned shift-amount width
- OUT_WIDTH, 8, signed quantised output width
- TABLE_DEPTH, 64, scale-table entries (channels); ADDR_W = clog2(TABLE_DEPTH)
- SAT_CNT_WIDTH, 16, saturation counter width

Ports:
- clk  in  1  clock
- quantify_reset  in  1  synchronous active-high reset
- mode  in  1  0: every lane uses entry chan_base; 1: channel c uses entry chan_base+c (mod TABLE_DEPTH)
- relu_en  in  1  clamp negative results to 0
- in_valid  in  1  input row valid
- in_ready  out  1  input accepted when in_valid&&in_ready
- in_row  in  LANES*CHANNELS*PIXEL_WIDTH  signed pixels; channel c, lane l at index (c*LANES+l)
- in_chan_base  in  ADDR_W  first table entry for this row
- tbl_we  in  1  table write strobe
- tbl_addr  in  ADDR_W  table write address
- tbl_tail  in  TAIL_WIDTH  scale tail to write
- tbl_rank  in  RANK_WIDTH  rank to write
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts
- out_row  out  LANES*CHANNELS*OUT_WIDTH  quantised pixels, same ordering as in_row
- sat_clear  in  1  clear saturation counter
- sat_count  out  SAT_CNT_WIDTH  saturated pixels since last clear

Behaviour:
- Pipeline has 3 stages: S1 captures row, mode, relu_en and table lookup; S2 forms products; S3 does shift/round/saturate and is the output register.
- Latency: 3 clk from accept to out_valid when unstalled. Throughput is 1 row/clk.
- Global advance enable adv = out_ready || !out_valid. All stage registers and their valid bits move only when adv=1.
- in_ready = adv (combinational). A bubble (in_valid=0) propagates as valid=0.
- out_row and out_valid hold stable while out_valid=1 && out_ready=0.
- Table write: tbl_we writes {tail,rank} at tbl_addr at the clock edge.
  - An S1 lookup in the same cycle as a write to the same address returns the OLD entry.
  - Writes are accepted regardless of stall.
- Table contents are not reset; software must load entries before use.
- Product P = signed(pixel) * unsigned(tail), width PIXEL_WIDTH+TAIL_WIDTH+1, signed.
- Shift: r = min(rank, PIXEL_WIDTH+TAIL_WIDTH).
  - r=0: Q = P.
  - r>0: Q = (P + 2^(r-1)) >>> r, arithmetic shift, computed without overflow.
- Saturation:
  - Q > 2^(OUT_WIDTH-1)-1 gives max; Q < -2^(OUT_WIDTH-1) gives min; both flag saturation.
  - When relu_en=1 and Q<0, the output is 0 and this is not counted as saturation.
- sat_count adds the number of saturating lanes in each row leaving S3 (counted once, on the out_valid&&out_ready handshake). It sticks at all-ones.
- sat_clear zeroes sat_count. If sat_clear and a handshake occur in the same cycle, the result is the new row's count.
- Reset: out_valid=0, all stage valids=0, out_row=0, sat_count=0.
  - in_ready=1 in the cycle after reset releases.
  - Rows in flight at reset are discarded, with no output.
  - tbl_we during reset is ignored.
- mode=0: the CHANNELS groups are treated as one wide channel, and all lanes use entry chan_base.
- mode=1 with chan_base+c >= TABLE_DEPTH wraps modulo TABLE_DEPTH.

Test Plan:
- Load entry 0 = {tail 0x6000, rank 15}, mode=1, pixel 100 on ch0 -> output 75 after exactly 3 clk, sat_count=0.
- Entry 1 = {1,1}, ch1 pixels 3, -3, 1, -1 -> outputs 2, -1, 1, 0. With relu_en=1 -> 2, 0, 1, 0.
- Entry 0 = {0x4000, 14}, pixels 1000 and -1000 in all 64 lanes -> all lanes 127 / -128, sat_count=64.
  - Repeat with sat_clear asserted on the handshake cycle -> count 64, not 128.
- Stream 5 rows, hold out_ready=0 for cycles 4-7 -> in_ready=0 while stalled, out_row constant, no row lost or duplicated, and in-order delivery after release.
- Write entry 2 = {tail 2, rank 0} in the same cycle a row with chan_base=2 is accepted (old tail 1) -> that row uses old tail. The next row uses tail 2, so pixel 10 -> 20.
- Assert quantify_reset with 2 rows in flight -> out_valid=0 and sat_count=0 next cycle, no stale row emitted. Table entries retained.
